// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and the score saturation helper
// for the fully-connected classifier.
package fc_pkg;

  localparam int DW    = 16;
  localparam int ACC_W = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Scale the accumulator down, then clamp it into the signed DW-bit range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] acc,
                                                  input int unsigned shift);
    logic signed [ACC_W-1:0] s;
    s = acc >>> shift;
    if (s > SAT_MAX)      sat_dw = SAT_MAX[DW-1:0];
    else if (s < SAT_MIN) sat_dw = SAT_MIN[DW-1:0];
    else                  sat_dw = s[DW-1:0];
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One class lane: registers ReLU(x) and its weight, then multiplies and
// accumulates the full-precision product on the following cycle.
module fc_mac_lane
  import fc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    x_i,
  input  logic signed [DW-1:0]    w_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [DW-1:0]    x_q, w_q;
  logic                    v_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [2*DW-1:0]  prod;

  assign prod  = x_q * w_q;
  assign acc_o = acc_q;

  // Clear wins over a pending product; it is only raised when no frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      w_q   <= '0;
      v_q   <= 1'b0;
      acc_q <= '0;
    end else if (clr_i) begin
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      v_q <= en_i;
      if (en_i) begin
        x_q <= x_i[DW-1] ? '0 : x_i;
        w_q <= w_i;
      end
      if (v_q) acc_q <= acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected output layer: weight memory, frame control FSM, N_OUT MAC
// lanes, and the handshaked score drain with a running argmax.
module fc_classifier
  import fc_pkg::*;
#(
  parameter int N_IN  = 9,
  parameter int N_OUT = 4,
  parameter int SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_load,
  input  logic signed [DW-1:0]       w_in,
  input  logic                       in_valid,
  input  logic signed [DW-1:0]       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DW-1:0]       out_data,
  output logic [$clog2(N_OUT)-1:0]   out_idx,
  output logic                       class_valid,
  output logic [$clog2(N_OUT)-1:0]   class_id,
  output logic                       w_ready,
  output logic                       busy,
  output logic [1:0]                 err
);

  localparam int IW    = $clog2(N_OUT);
  localparam int KW    = $clog2(N_IN + 1);
  localparam int NW    = N_IN * N_OUT;
  localparam int PW    = $clog2(NW);
  localparam logic [KW-1:0] LAST_K   = KW'(N_IN - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);
  localparam logic [PW-1:0] LAST_P   = PW'(NW - 1);

  state_e               state_q, state_d;
  logic [KW-1:0]        inCnt_q, inCnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [DW-1:0] bestVal_q, bestVal_d;
  logic [IW-1:0]        bestIdx_q, bestIdx_d;
  logic                 classValid_q, classValid_d;
  logic [IW-1:0]        classId_q, classId_d;
  logic [1:0]           err_q, err_d;
  logic [PW-1:0]        wPtr_q, wPtr_d;
  logic                 wReady_q, wReady_d;

  logic signed [DW-1:0]    wMem [NW];
  logic signed [DW-1:0]    colW [N_OUT];
  logic signed [ACC_W-1:0] acc  [N_OUT];
  logic signed [DW-1:0]    score;
  logic                    accept, clr, wrEn, takeNew;

  assign wrEn    = w_load && (state_q == IDLE);
  assign score   = sat_dw(acc[idx_q], SHIFT);
  assign takeNew = (idx_q == '0) || (score > bestVal_q);
  assign clr     = (state_q == DRAIN) && (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (wrEn) wMem[wPtr_q] <= w_in;
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) colW[j] = wMem[PW'(j * N_IN) + PW'(inCnt_q)];
  end

  for (genvar j = 0; j < N_OUT; j++) begin : gLane
    fc_mac_lane uLane (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .en_i  (accept),
      .x_i   (in_data),
      .w_i   (colW[j]),
      .acc_o (acc[j])
    );
  end

  always_comb begin
    state_d      = state_q;
    inCnt_d      = inCnt_q;
    idx_d        = idx_q;
    bestVal_d    = bestVal_q;
    bestIdx_d    = bestIdx_q;
    classValid_d = 1'b0;
    classId_d    = classId_q;
    err_d        = err_q;
    wPtr_d       = wPtr_q;
    wReady_d     = wReady_q;
    accept       = 1'b0;

    if (wrEn) begin
      wPtr_d = (wPtr_q == LAST_P) ? '0 : wPtr_q + 1'b1;
      if (wPtr_q == LAST_P) wReady_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && wReady_q) begin
          accept = 1'b1;
          if (N_IN == 1) begin
            state_d = FLUSH;
          end else if (in_last) begin
            state_d  = FLUSH;
            err_d[1] = 1'b1;
          end else begin
            state_d = ACCUM;
            inCnt_d = KW'(1);
          end
        end
      end
      ACCUM: begin
        // A value arriving with in_last is counted before the frame closes.
        if (in_valid) begin
          accept = 1'b1;
          if (inCnt_q == LAST_K) begin
            state_d = FLUSH;
            inCnt_d = '0;
          end else if (in_last) begin
            state_d  = FLUSH;
            inCnt_d  = '0;
            err_d[1] = 1'b1;
          end else begin
            inCnt_d = inCnt_q + 1'b1;
          end
        end else if (in_last) begin
          state_d  = FLUSH;
          inCnt_d  = '0;
          err_d[1] = 1'b1;
        end
      end
      FLUSH: begin
        if (in_valid) err_d[0] = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (in_valid) err_d[0] = 1'b1;
        if (out_ready) begin
          if (takeNew) begin
            bestVal_d = score;
            bestIdx_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d      = IDLE;
            idx_d        = '0;
            classValid_d = 1'b1;
            classId_d    = takeNew ? idx_q : bestIdx_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      inCnt_q      <= '0;
      idx_q        <= '0;
      bestVal_q    <= '0;
      bestIdx_q    <= '0;
      classValid_q <= 1'b0;
      classId_q    <= '0;
      err_q        <= '0;
      wPtr_q       <= '0;
      wReady_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      inCnt_q      <= inCnt_d;
      idx_q        <= idx_d;
      bestVal_q    <= bestVal_d;
      bestIdx_q    <= bestIdx_d;
      classValid_q <= classValid_d;
      classId_q    <= classId_d;
      err_q        <= err_d;
      wPtr_q       <= wPtr_d;
      wReady_q     <= wReady_d;
    end
  end

  assign out_valid   = (state_q == DRAIN);
  assign out_data    = out_valid ? score : '0;
  assign out_idx     = idx_q;
  assign class_valid = classValid_q;
  assign class_id    = classId_q;
  assign w_ready     = wReady_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Directed, table-driven bench for fc_classifier with hand-computed scores,
// plus sequences for backpressure, overrun and mid-frame reset.
module tb_fc_classifier;

  logic               clk;
  logic               rst;
  logic               w_load;
  logic signed [15:0] w_in;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [1:0]         out_idx;
  logic               class_valid;
  logic [1:0]         class_id;
  logic               w_ready;
  logic               busy;
  logic [1:0]         err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int w0, w1, w2, w3;
    int x;
    int nIn;
    int lastMode;
    int e0, e1, e2, e3;
    int expClass;
    int expErr;
  } vec_t;

  vec_t vecs [7];

  fc_classifier dut (
    .clk         (clk),
    .rst         (rst),
    .w_load      (w_load),
    .w_in        (w_in),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .class_valid (class_valid),
    .class_id    (class_id),
    .w_ready     (w_ready),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wOf(input vec_t v, input int j);
    case (j)
      0:       return v.w0;
      1:       return v.w1;
      2:       return v.w2;
      default: return v.w3;
    endcase
  endfunction

  function automatic int expOf(input vec_t v, input int j);
    case (j)
      0:       return v.e0;
      1:       return v.e1;
      2:       return v.e2;
      default: return v.e3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyReset(input bit doChecks);
    rst       = 1'b1;
    w_load    = 1'b0;
    w_in      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    if (doChecks) begin
      checkOutput("rst.out_valid", int'(out_valid), 0);
      checkOutput("rst.out_data", int'(out_data), 0);
      checkOutput("rst.out_idx", int'(out_idx), 0);
      checkOutput("rst.class_valid", int'(class_valid), 0);
      checkOutput("rst.class_id", int'(class_id), 0);
      checkOutput("rst.w_ready", int'(w_ready), 0);
      checkOutput("rst.busy", int'(busy), 0);
      checkOutput("rst.err", int'(err), 0);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic loadWeights(input vec_t v);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 9; k++) begin
        w_load = 1'b1;
        w_in   = 16'(wOf(v, j));
        if (j == 3 && k == 8) checkOutput("w_ready.beforeLast", int'(w_ready), 0);
        tick();
      end
    end
    w_load = 1'b0;
    checkOutput("w_ready.afterLast", int'(w_ready), 1);
  endtask

  // lastMode: 0 = full frame, 1 = in_last alone after the values, 2 = in_last with the final value
  task automatic applyStimulus(input int x, input int n, input int lastMode);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(x);
      in_last  = (lastMode == 2) && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (lastMode == 1) begin
      in_last = 1'b1;
      tick();
      in_last = 1'b0;
    end
  endtask

  task automatic checkLatency(input string tag);
    checkOutput({tag, ".latency.t1"}, int'(out_valid), 0);
    tick();
    checkOutput({tag, ".latency.t2"}, int'(out_valid), 1);
  endtask

  task automatic drainCheck(input vec_t v, input int stallIdx, input int stallCycles, input string tag);
    for (int i = 0; i < 4; i++) begin
      if (i == stallIdx) begin
        out_ready = 1'b0;
        w_load    = 1'b1;
        w_in      = 16'sd999;
        for (int c = 0; c < stallCycles; c++) begin
          checkOutput($sformatf("%s.stall%0d.idx", tag, c), int'(out_idx), i);
          checkOutput($sformatf("%s.stall%0d.data", tag, c), int'(out_data), expOf(v, i));
          checkOutput($sformatf("%s.stall%0d.valid", tag, c), int'(out_valid), 1);
          tick();
        end
        w_load    = 1'b0;
        out_ready = 1'b1;
      end
      checkOutput($sformatf("%s.idx%0d", tag, i), int'(out_idx), i);
      checkOutput($sformatf("%s.score%0d", tag, i), int'(out_data), expOf(v, i));
      checkOutput($sformatf("%s.class_valid.early%0d", tag, i), int'(class_valid), 0);
      tick();
    end
    checkOutput({tag, ".out_valid.after"}, int'(out_valid), 0);
    checkOutput({tag, ".class_valid"}, int'(class_valid), 1);
    checkOutput({tag, ".class_id"}, int'(class_id), v.expClass);
    tick();
    checkOutput({tag, ".class_valid.pulse"}, int'(class_valid), 0);
    checkOutput({tag, ".busy.after"}, int'(busy), 0);
  endtask

  initial begin
    int seen;
    vec_t vb;

    vecs[0] = '{1, 2, 3, 4, 2, 9, 0, 18, 36, 54, 72, 3, 0};
    vecs[1] = '{1, 2, 3, 4, -5, 9, 0, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{32767, 32767, 32767, 32767, 32767, 9, 0, 32767, 32767, 32767, 32767, 0, 0};
    vecs[3] = '{-32768, -32768, -32768, -32768, 32767, 9, 0, -32768, -32768, -32768, -32768, 0, 0};
    vecs[4] = '{1, -1, 2, -2, 2, 9, 0, 18, -18, 36, -36, 2, 0};
    vecs[5] = '{5, 5, 1, 1, 4, 9, 0, 180, 180, 36, 36, 0, 0};
    vecs[6] = '{1, 2, 3, 4, 3, 5, 2, 15, 30, 45, 60, 3, 2};

    applyReset(1'b1);

    // Inputs before any weights are loaded must be dropped.
    applyStimulus(2, 3, 0);
    checkOutput("noWeights.busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      applyReset(1'b0);
      loadWeights(vecs[i]);
      applyStimulus(vecs[i].x, vecs[i].nIn, vecs[i].lastMode);
      checkLatency($sformatf("v%0d", i));
      drainCheck(vecs[i], -1, 0, $sformatf("v%0d", i));
      checkOutput($sformatf("v%0d.err", i), int'(err), vecs[i].expErr);
    end

    // Backpressure at idx 1, with ignored weight writes during the stall.
    applyReset(1'b0);
    loadWeights(vecs[0]);
    applyStimulus(2, 9, 0);
    checkLatency("bp");
    drainCheck(vecs[0], 1, 3, "bp");
    applyStimulus(2, 9, 0);
    checkLatency("bp2");
    drainCheck(vecs[0], -1, 0, "bp2");

    // Short frame closed by a lone in_last, then an overrun during DRAIN.
    vb = '{1, 2, 3, 4, 2, 5, 1, 10, 20, 30, 40, 3, 3};
    applyReset(1'b0);
    loadWeights(vb);
    applyStimulus(2, 5, 1);
    checkLatency("ovr");
    checkOutput("ovr.err.short", int'(err), 2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'sd100;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("ovr.err.both", int'(err), 3);
    drainCheck(vb, -1, 0, "ovr");
    checkOutput("ovr.err.sticky", int'(err), 3);

    // Asynchronous reset in the middle of a frame.
    applyReset(1'b0);
    loadWeights(vecs[0]);
    applyStimulus(2, 4, 0);
    checkOutput("midRst.busyBefore", int'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst.busy", int'(busy), 0);
    checkOutput("midRst.out_valid", int'(out_valid), 0);
    checkOutput("midRst.w_ready", int'(w_ready), 0);
    checkOutput("midRst.err", int'(err), 0);
    checkOutput("midRst.out_data", int'(out_data), 0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 9);
      in_data  = 16'sd2;
      tick();
      if (out_valid || busy || class_valid) seen++;
    end
    in_valid = 1'b0;
    checkOutput("midRst.dropped", seen, 0);
    loadWeights(vecs[0]);
    applyStimulus(2, 9, 0);
    checkLatency("midRst.reload");
    drainCheck(vecs[0], -1, 0, "midRst.reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Fully-connected output layer directly downstream of the convolution/pooling stage.
- Consumes the serial stream of pooled 16-bit values plus the end-of-map strobe.
- Applies ReLU and multiplies each value against N_OUT preloaded weight columns in parallel, accumulating one score per class.
- Emits the N_OUT saturated scores over a valid/ready handshake, then a one-cycle argmax class result.

Parameters:
- N_IN, 9: pooled values per frame (3x3 pooled map).
- N_OUT, 4: number of output classes.
- DW, 16: data/weight width, signed.
- ACC_W, 40: accumulator width, signed.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- w_load  in  1  weight write strobe; one word per cycle.
- w_in  in  DW  signed weight.
- in_valid  in  1  pooled value strobe.
- in_data  in  DW  signed pooled value.
- in_last  in  1  end-of-frame strobe; driven from the pooling done strobe.
- out_valid  out  1  score valid.
- out_ready  in  1  downstream accepts score.
- out_data  out  DW  saturated signed score.
- out_idx  out  $clog2(N_OUT)  class index of out_data.
- class_valid  out  1  one-cycle argmax pulse.
- class_id  out  $clog2(N_OUT)  winning class.
- w_ready  out  1  weight memory fully loaded.
- busy  out  1  frame in progress or scores draining.
- err  out  2  sticky flags: [0] overrun, [1] short frame.

Behaviour:
- Reset (asynchronous, active-high) clears the following to 0: all outputs, accumulators, counters, write pointer, state = IDLE. Weight memory contents are don't-care and w_ready = 0.
- Reset mid-frame or mid-drain is legal: the frame is abandoned, and no out_valid or class_valid is produced for it.
- Weight load:
  - Accepted only in IDLE.
  - Address = write pointer p. Weight for class j, input k lives at p = j*N_IN + k.
  - p wraps to 0 after N_IN*N_OUT-1. w_ready is set when the final word is written and stays set until reset.
  - w_load outside IDLE is ignored and does not advance p.
- States:
  - IDLE -> ACCUM on the first accepted in_valid while w_ready = 1. in_valid while w_ready = 0 is dropped.
  - ACCUM: every in_valid is accepted and input counter k increments.
  - ACCUM -> FLUSH when k reaches N_IN (k = N_IN-1 accepted) or on in_last, whichever comes first.
  - in_last with fewer than N_IN values accepted sets err[1]; missing terms count as zero.
  - in_valid and in_last in the same cycle: the value is accepted first, then the frame ends.
  - FLUSH: one cycle so the final product reaches the accumulators.
  - FLUSH -> DRAIN.
  - DRAIN: present class i = 0..N_OUT-1 in order.
  - DRAIN -> IDLE after the final handshake.
- Datapath:
  - Stage 1 registers x = max(in_data, 0) (ReLU) and the N_OUT weights at column k.
  - Stage 2 forms the full-precision product (2*DW bits), sign-extends it to ACC_W and adds it into acc[j].
  - No overflow wrap within ACC_W for the default sizes.
- Latency: the last value accepted in cycle t produces out_valid high from cycle t+2, with out_idx = 0.
- Output:
  - out_data = saturate_DW(acc[out_idx] >>> SHIFT), clamped to [-32768, 32767].
  - out_data and out_idx are held stable while out_valid && !out_ready.
  - A handshake (out_valid && out_ready) advances out_idx. After the last handshake, out_valid drops in the next cycle.
- Argmax:
  - Running max of the saturated scores over the drain. Ties go to the lowest index.
  - class_valid pulses one cycle, in the cycle after the last handshake, with class_id.
  - Accumulators clear on entry to IDLE.
- Overrun: in_valid during FLUSH or DRAIN is dropped and sets err[0].
- err bits clear only on reset.
- busy = (state != IDLE).

Decomposition:
- Shared package fc_pkg:
  - Constants DW, ACC_W.
  - State enum {IDLE, ACCUM, FLUSH, DRAIN}.
  - Function sat_dw(acc, shift).
- One sub-module fc_mac_lane, instantiated N_OUT times: register the ReLU'd x and weight, multiply, accumulate, synchronous clear.
- Control FSM, weight memory and drain/argmax logic live in the top.

Test Plan:
- Weights for class j all = j+1, 9 inputs of 2, out_ready = 1 -> scores 18, 36, 54, 72 at idx 0..3; out_valid rises 2 cycles after the last input; class_valid with class_id = 3.
- Inputs all -5, weights as above -> ReLU zeroes them: all scores 0, class_id = 0 (tie to lowest), err = 0.
- Weights all 32767, inputs all 32767, SHIFT = 0 -> every out_data = 32767 (saturated). Weights all -32768 -> out_data = -32768.
- out_ready low for 3 cycles at idx 1 -> out_data = 36 and out_idx = 1 held for 3 cycles; sequence completes intact afterwards.
- in_last after 5 inputs of 2 -> err[1] = 1; scores 10, 20, 30, 40. Extra in_valid during DRAIN -> err[0] = 1, scores unchanged.
- rst pulse after 4 inputs -> all outputs 0 asynchronously, no out_valid; w_ready = 0, and new input is dropped until weights are reloaded.
